// File: rtl/ram_pkg.sv
// ram_pkg: read/write select encoding shared by the scratch memory and its users.
package ram_pkg;
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/ram.sv
// ram: single-port scratch memory with registered read data and synchronous active-low clear.
module ram
  import ram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ADDR  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [ADDR-1:0]  i_addr,
  input  logic             i_rw,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);
  localparam int DEPTH = 1 << ADDR;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] data_q;
  // Read data only updates in read mode, so it holds across any write-mode cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      data_q <= '0;
    end else if (i_rw == RW_WRITE) begin
      if (i_wen) mem_q[i_addr] <= i_data;
    end else begin
      data_q <= mem_q[i_addr];
    end
  end
  assign o_data = data_q;
endmodule

// File: tb/tb_ram.sv
// tb_ram: directed stimulus against an array model of the memory, checked every cycle and by literals.
module tb_ram;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [1:0] i_addr = '0;
  logic       i_rw = 1'b0;
  logic       i_wen = 1'b0;
  logic [1:0] i_data = '0;
  logic [1:0] o_data;
  int errors = 0;
  int checks = 0;
  logic [1:0] mdl_mem [4];
  logic [1:0] mdl_out;
  logic       mdl_valid = 1'b0;

  ram #(.WIDTH(2), .ADDR(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_rw(i_rw),
    .i_wen(i_wen), .i_data(i_data), .o_data(o_data)
  );

  always #5 i_clk = ~i_clk;

  // Model: memory as a plain array; read port is whatever was last read, zero after reset.
  always @(posedge i_clk) begin
    if (!i_rst) begin
      for (int k = 0; k < 4; k++) mdl_mem[k] <= 2'd0;
      mdl_out   <= 2'd0;
      mdl_valid <= 1'b1;
    end else if (i_rw) begin
      if (i_wen) mdl_mem[i_addr] <= i_data;
    end else begin
      mdl_out <= mdl_mem[i_addr];
    end
  end

  always @(negedge i_clk) begin
    if (mdl_valid) begin
      checks++;
      if (o_data !== mdl_out) begin
        errors++;
        $display("FAIL model t=%0t: o_data=%b expected %b", $time, o_data, mdl_out);
      end
    end
  end

  task automatic step(input logic rst, input logic rw, input logic wen,
                      input logic [1:0] addr, input logic [1:0] data);
    i_rst = rst; i_rw = rw; i_wen = wen; i_addr = addr; i_data = data;
    @(posedge i_clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] addr);
    step(1'b1, 1'b0, 1'b0, addr, 2'd0);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [1:0] data);
    step(1'b1, 1'b1, 1'b1, addr, data);
  endtask

  task automatic chk(input string name, input logic [1:0] exp);
    checks++;
    if (o_data !== exp) begin
      errors++;
      $display("FAIL %s: o_data=%b expected %b", name, o_data, exp);
    end
  endtask

  task automatic load;
    wr(2'd1, 2'b01);
    wr(2'd2, 2'b10);
    wr(2'd3, 2'b11);
  endtask

  initial begin
    logic [1:0] seq [8];
    logic [1:0] val [4];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    val = '{2'b00, 2'b01, 2'b10, 2'b11};
    // 1: reset, then every address reads zero
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    chk("reset_out", 2'b00);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      chk($sformatf("reset_rd%0d", a), 2'b00);
    end
    // 2: write then read back
    load();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      chk($sformatf("readback%0d", a), val[a]);
    end
    // 3: write gating
    step(1'b1, 1'b1, 1'b0, 2'd0, 2'b11);
    rd(2'd0);
    chk("wen0_no_write", 2'b00);
    step(1'b1, 1'b0, 1'b1, 2'd0, 2'b11);
    chk("rw0_wen1_read", 2'b00);
    rd(2'd0);
    chk("rw0_no_write", 2'b00);
    // 4: output holds through write mode
    rd(2'd3);
    chk("hold_pre", 2'b11);
    wr(2'd3, 2'b01);
    chk("hold_write", 2'b11);
    step(1'b1, 1'b1, 1'b0, 2'd3, 2'b10);
    chk("hold_idle", 2'b11);
    rd(2'd3);
    chk("hold_after", 2'b01);
    // 5: reset during a write discards it
    load();
    rd(2'd1);
    chk("mid_pre", 2'b01);
    step(1'b0, 1'b1, 1'b1, 2'd0, 2'b11);
    chk("mid_reset_out", 2'b00);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a));
      chk($sformatf("mid_rd%0d", a), 2'b00);
    end
    // 6: address toggled every cycle, one-cycle latency
    load();
    for (int n = 0; n < 8; n++) begin
      rd(seq[n]);
      chk($sformatf("latency%0d", n), val[seq[n]]);
    end
    @(negedge i_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
